// File: rtl/update_accum.sv
// update_accum: two-lane vertex update accumulator.
// Two registered stages (P1 read/add, P2 write-back) feed a flop array; a
// P2->P1 bypass resolves read-after-write so accumulation never stalls.
// A drain command empties the pipeline, then streams and clears every entry.
module update_accum #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned VID_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InputValid_A,
   input  logic              InputValid_B,
   input  logic [DATA_W-1:0] InDestVid_A,
   input  logic [DATA_W-1:0] InDestVid_B,
   input  logic [DATA_W-1:0] InUpdate_A,
   input  logic [DATA_W-1:0] InUpdate_B,
   input  logic              start_drain,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [VID_W-1:0]  out_vid,
   output logic [DATA_W-1:0] out_value,
   output logic              drain_done,
   output logic              busy,
   output logic              err_drop,
   output logic              err_range
);

   localparam int unsigned DEPTH = 2 ** VID_W;
   localparam logic [VID_W-1:0] LAST_IDX = VID_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_ACCUM      = 2'd0,
      S_WAIT_EMPTY = 2'd1,
      S_DRAIN      = 2'd2
   } state_t;

   // FSM state
   state_t r_state;
   state_t w_state_nxt;

   // Per-vertex accumulators
   logic [DATA_W-1:0] r_mem [DEPTH];

   // P1: registered input tuples
   logic              r_p1_va;
   logic              r_p1_vb;
   logic [VID_W-1:0]  r_p1_vid_a;
   logic [VID_W-1:0]  r_p1_vid_b;
   logic [DATA_W-1:0] r_p1_upd_a;
   logic [DATA_W-1:0] r_p1_upd_b;

   // P2: registered sums awaiting write-back
   logic              r_p2_va;
   logic              r_p2_vb;
   logic [VID_W-1:0]  r_p2_vid_a;
   logic [VID_W-1:0]  r_p2_vid_b;
   logic [DATA_W-1:0] r_p2_sum_a;
   logic [DATA_W-1:0] r_p2_sum_b;

   // Drain stream and status registers
   logic [VID_W-1:0]  r_idx;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_value;
   logic              r_drain_done;
   logic              r_busy;
   logic              r_err_drop;
   logic              r_err_range;

   // Combinational intermediates
   logic              w_open;
   logic              w_hi_ok_a;
   logic              w_hi_ok_b;
   logic              w_take_a;
   logic              w_take_b;
   logic              w_range_hit;
   logic              w_drop_hit;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic              w_merge;
   logic [DATA_W-1:0] w_sum_a;
   logic [DATA_W-1:0] w_sum_b;
   logic              w_pipe_empty;
   logic              w_accept;
   logic [VID_W-1:0]  w_idx_nxt;
   logic              w_done_nxt;
   logic              w_out_valid_nxt;
   logic [DATA_W-1:0] w_out_value_nxt;
   logic              w_busy_nxt;

   assign w_pipe_empty = !r_p1_va && !r_p1_vb && !r_p2_va && !r_p2_vb;
   assign w_accept     = (r_state == S_DRAIN) && r_out_valid && out_ready;

   // Input qualification: lanes enter only in ACCUM, without a drain request, and in range
   always_comb begin
      w_open      = (r_state == S_ACCUM) && !start_drain;
      w_hi_ok_a   = (InDestVid_A >> VID_W) == '0;
      w_hi_ok_b   = (InDestVid_B >> VID_W) == '0;
      w_take_a    = InputValid_A && w_open && w_hi_ok_a;
      w_take_b    = InputValid_B && w_open && w_hi_ok_b;
      w_range_hit = (InputValid_A && w_open && !w_hi_ok_a) ||
                    (InputValid_B && w_open && !w_hi_ok_b);
      w_drop_hit  = (InputValid_A || InputValid_B) && !w_open;
   end

   // P1 capture of accepted tuples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_p1_va    <= 1'b0;
         r_p1_vb    <= 1'b0;
         r_p1_vid_a <= '0;
         r_p1_vid_b <= '0;
         r_p1_upd_a <= '0;
         r_p1_upd_b <= '0;
      end else begin
         r_p1_va    <= w_take_a;
         r_p1_vb    <= w_take_b;
         r_p1_vid_a <= InDestVid_A[VID_W-1:0];
         r_p1_vid_b <= InDestVid_B[VID_W-1:0];
         r_p1_upd_a <= InUpdate_A;
         r_p1_upd_b <= InUpdate_B;
      end
   end

   // P1 operand fetch with P2 bypass, and same-vid lane merge
   always_comb begin
      w_op_a = r_mem[r_p1_vid_a];
      if (r_p2_vb && (r_p2_vid_b == r_p1_vid_a)) w_op_a = r_p2_sum_b;
      if (r_p2_va && (r_p2_vid_a == r_p1_vid_a)) w_op_a = r_p2_sum_a;

      w_op_b = r_mem[r_p1_vid_b];
      if (r_p2_vb && (r_p2_vid_b == r_p1_vid_b)) w_op_b = r_p2_sum_b;
      if (r_p2_va && (r_p2_vid_a == r_p1_vid_b)) w_op_b = r_p2_sum_a;

      // Same destination on both lanes folds B into A's single write
      w_merge = r_p1_va && r_p1_vb && (r_p1_vid_a == r_p1_vid_b);
      w_sum_a = w_op_a + r_p1_upd_a + (w_merge ? r_p1_upd_b : '0);
      w_sum_b = w_op_b + r_p1_upd_b;
   end

   // P2 capture of sums
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_p2_va    <= 1'b0;
         r_p2_vb    <= 1'b0;
         r_p2_vid_a <= '0;
         r_p2_vid_b <= '0;
         r_p2_sum_a <= '0;
         r_p2_sum_b <= '0;
      end else begin
         r_p2_va    <= r_p1_va;
         r_p2_vb    <= r_p1_vb && !w_merge;
         r_p2_vid_a <= r_p1_vid_a;
         r_p2_vid_b <= r_p1_vid_b;
         r_p2_sum_a <= w_sum_a;
         r_p2_sum_b <= w_sum_b;
      end
   end

   // Array write-back from P2 and clear-on-read during drain (never concurrent)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem <= '{default: '0};
      end else begin
         if (r_p2_va) r_mem[r_p2_vid_a] <= r_p2_sum_a;
         if (r_p2_vb) r_mem[r_p2_vid_b] <= r_p2_sum_b;
         if (w_accept) r_mem[r_idx] <= '0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_ACCUM;
      else      r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ACCUM:      if (start_drain) w_state_nxt = S_WAIT_EMPTY;
         S_WAIT_EMPTY: if (w_pipe_empty) w_state_nxt = S_DRAIN;
         S_DRAIN:      if (w_accept && (r_idx == LAST_IDX)) w_state_nxt = S_ACCUM;
         default:      w_state_nxt = S_ACCUM;
      endcase
   end

   // FSM output logic: next values for the registered drain stream and status
   always_comb begin
      w_idx_nxt  = '0;
      w_done_nxt = 1'b0;
      if (r_state == S_DRAIN) begin
         w_idx_nxt = r_idx;
         if (w_accept) begin
            w_idx_nxt  = r_idx + VID_W'(1);
            w_done_nxt = (r_idx == LAST_IDX);
         end
      end
      w_out_valid_nxt = (w_state_nxt == S_DRAIN);
      w_busy_nxt      = (w_state_nxt != S_ACCUM);
      w_out_value_nxt = w_out_valid_nxt ? r_mem[w_idx_nxt] : '0;
   end

   // Registered drain stream and status outputs; error flags are sticky
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx        <= '0;
         r_out_valid  <= 1'b0;
         r_out_value  <= '0;
         r_drain_done <= 1'b0;
         r_busy       <= 1'b0;
         r_err_drop   <= 1'b0;
         r_err_range  <= 1'b0;
      end else begin
         r_idx        <= w_idx_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_out_value  <= w_out_value_nxt;
         r_drain_done <= w_done_nxt;
         r_busy       <= w_busy_nxt;
         r_err_drop   <= r_err_drop | w_drop_hit;
         r_err_range  <= r_err_range | w_range_hit;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_vid    = r_idx;
   assign out_value  = r_out_value;
   assign drain_done = r_drain_done;
   assign busy       = r_busy;
   assign err_drop   = r_err_drop;
   assign err_range  = r_err_range;

endmodule

// File: tb/tb_update_accum.sv
// Scoreboard bench for update_accum: drains push expected beats, a monitor checks them.
module tb_update_accum;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned VID_W  = 8;
   localparam int unsigned DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              InputValid_A, InputValid_B;
   logic [DATA_W-1:0] InDestVid_A, InDestVid_B;
   logic [DATA_W-1:0] InUpdate_A, InUpdate_B;
   logic              start_drain;
   logic              out_ready;
   logic              out_valid;
   logic [VID_W-1:0]  out_vid;
   logic [DATA_W-1:0] out_value;
   logic              drain_done;
   logic              busy;
   logic              err_drop;
   logic              err_range;

   update_accum #(.DATA_W(DATA_W), .VID_W(VID_W)) dut (
      .clk(clk), .rst(rst),
      .InputValid_A(InputValid_A), .InputValid_B(InputValid_B),
      .InDestVid_A(InDestVid_A), .InDestVid_B(InDestVid_B),
      .InUpdate_A(InUpdate_A), .InUpdate_B(InUpdate_B),
      .start_drain(start_drain), .out_ready(out_ready),
      .out_valid(out_valid), .out_vid(out_vid), .out_value(out_value),
      .drain_done(drain_done), .busy(busy),
      .err_drop(err_drop), .err_range(err_range)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [VID_W-1:0]  vid;
      logic [DATA_W-1:0] value;
   } beat_t;

   beat_t             sb[$];
   logic [DATA_W-1:0] exp_mem [DEPTH];
   int                total = 0;
   int                bad   = 0;
   logic              pend_done = 1'b0;
   int                pat [4] = '{1, 0, 0, 1};

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: compares each presented beat with the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         pend_done = 1'b0;
      end else begin
         check("drain_done", 32'(drain_done), 32'(pend_done));
         pend_done = 1'b0;
         if (out_valid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got vid %0d value 0x%0h with empty scoreboard",
                        out_vid, out_value);
            end else begin
               check("out_vid", 32'(out_vid), 32'(sb[0].vid));
               check("out_value", out_value, sb[0].value);
               if (out_ready) begin
                  if (sb[0].vid == VID_W'(DEPTH - 1)) pend_done = 1'b1;
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      InputValid_A = 1'b0;
      InputValid_B = 1'b0;
      InDestVid_A  = '0;
      InDestVid_B  = '0;
      InUpdate_A   = '0;
      InUpdate_B   = '0;
   endtask

   task automatic drive(input logic va, input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] ua,
                        input logic vb, input logic [DATA_W-1:0] db, input logic [DATA_W-1:0] ub);
      InputValid_A = va; InDestVid_A = da; InUpdate_A = ua;
      InputValid_B = vb; InDestVid_B = db; InUpdate_B = ub;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_out_vid"}, 32'(out_vid), 32'(0));
      check({tag, "_out_value"}, out_value, 32'(0));
      check({tag, "_drain_done"}, 32'(drain_done), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_err_drop"}, 32'(err_drop), 32'(0));
      check({tag, "_err_range"}, 32'(err_range), 32'(0));
   endtask

   // Issue start_drain, queue the expected image, optionally inject a late input
   task automatic begin_drain(input bit inject);
      beat_t b;
      idle();
      start_drain = 1'b1;
      tick();
      start_drain = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         b.vid   = VID_W'(i);
         b.value = exp_mem[i];
         sb.push_back(b);
         exp_mem[i] = '0;
      end
      if (inject) begin
         InputValid_A = 1'b1;
         InDestVid_A  = 32'd2;
         InUpdate_A   = 32'd100;
      end
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'(1));
      tick();
      idle();
      @(negedge clk);
      if (!out_valid) @(negedge clk);
      check("first_valid_latency", 32'(out_valid), 32'(1));
   endtask

   task automatic finish_drain(input bit toggle);
      int k = 0;
      int guard = 0;
      while (sb.size() != 0 && guard < 3000) begin
         @(posedge clk);
         #1;
         if (toggle) out_ready = (pat[k % 4] != 0);
         k++;
         guard++;
      end
      out_ready = 1'b1;
      if (guard >= 3000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d beats left want 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      @(negedge clk);
      check("busy_after_drain", 32'(busy), 32'(0));
      check("out_valid_after_drain", 32'(out_valid), 32'(0));
   endtask

   initial begin
      int guard;
      rst = 1'b0;
      start_drain = 1'b0;
      out_ready = 1'b1;
      idle();
      for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;

      #2;
      check_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      tick();

      // Empty drain: all zeros, flags clear
      begin_drain(1'b0);
      finish_drain(1'b0);
      check("err_drop_idle", 32'(err_drop), 32'(0));
      check("err_range_idle", 32'(err_range), 32'(0));

      // Consecutive same-vid updates, P2 lane-B bypass, same-cycle merge
      drive(1, 32'd5, 32'd1, 1, 32'd6, 32'd10);
      drive(1, 32'd5, 32'd2, 1, 32'd6, 32'd10);
      drive(1, 32'd5, 32'd3, 1, 32'd6, 32'd10);
      drive(1, 32'd7, 32'd1, 1, 32'd9, 32'd5);
      drive(1, 32'd9, 32'd7, 1, 32'd12, 32'd3);
      drive(1, 32'd7, 32'd4, 1, 32'd7, 32'd9);
      idle();
      exp_mem[5]  = 32'd6;
      exp_mem[6]  = 32'd30;
      exp_mem[7]  = 32'd14;
      exp_mem[9]  = 32'd12;
      exp_mem[12] = 32'd3;
      begin_drain(1'b0);
      finish_drain(1'b0);

      // Second drain after clear returns zeros
      begin_drain(1'b0);
      finish_drain(1'b0);

      // Out-of-range id is dropped; in-range lane B still lands
      drive(1, 32'h100, 32'd55, 1, 32'd3, 32'd8);
      idle();
      @(negedge clk);
      check("err_range_set", 32'(err_range), 32'(1));
      check("err_drop_not_set", 32'(err_drop), 32'(0));
      exp_mem[3] = 32'd8;
      begin_drain(1'b1);
      check("err_drop_set", 32'(err_drop), 32'(1));
      finish_drain(1'b0);

      // Wraparound add and stalled drain stream
      drive(1, 32'd0, 32'hFFFF_FFFF, 1, 32'd255, 32'hA5);
      drive(1, 32'd0, 32'd2, 0, 32'd0, 32'd0);
      idle();
      exp_mem[0]   = 32'd1;
      exp_mem[255] = 32'hA5;
      begin_drain(1'b0);
      finish_drain(1'b1);

      // Asynchronous reset in the middle of a drain
      drive(1, 32'd1, 32'd7, 0, 32'd0, 32'd0);
      idle();
      tick();
      exp_mem[1] = 32'd7;
      begin_drain(1'b0);
      guard = 0;
      while (!(out_valid && out_vid == VID_W'(3)) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total++;
         bad++;
         $display("FAIL reach_idx3: got vid %0d want 3", out_vid);
      end
      #1 rst = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      sb.delete();
      for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      tick();
      begin_drain(1'b0);
      finish_drain(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
